sinogram_fill_scheduler: RTL and testbench

SINOGRAM_FILL_SCHEDULER -- requirements
Module: sinogram_fill_scheduler

---
 rtl/sinogram_fill_scheduler_pkg.sv | 26 ++
 rtl/sinogram_fill_scheduler_if.sv | 29 ++
 rtl/sinogram_fill_scheduler_rr_arbiter.sv | 29 ++
 rtl/sinogram_fill_scheduler.sv | 118 +++++++++++
 tb/tb_sinogram_fill_scheduler.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/sinogram_fill_scheduler_pkg.sv
// rtl/sinogram_fill_scheduler_pkg.sv - shared widths and state encoding for the sinogram fill scheduler
package sinogram_fill_scheduler_pkg;

  localparam int kDefNoOfBanks  = 4;
  localparam int kDefLineSize   = 256;
  localparam int kDefNoOfAngles = 180;
  localparam int kDefDataLength = 16;

  // Sample index within a line, and the angle field carried on req_angle
  localparam int kSLength     = $clog2(kDefLineSize);
  localparam int kAngleLength = 8;

  // Address is {angle, s}: wide enough for any 8-bit angle, so base+s never carries
  localparam int kSinogramAddressLength = kAngleLength + kSLength;

  localparam int kBankIdxLength = (kDefNoOfBanks > 1) ? $clog2(kDefNoOfBanks) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

endpackage

// File: rtl/sinogram_fill_scheduler_if.sv
// rtl/sinogram_fill_scheduler_if.sv - request, sinogram-read and filtered-write signal bundle
interface sinogram_fill_scheduler_if;
  import sinogram_fill_scheduler_pkg::*;

  logic [kDefNoOfBanks-1:0]              req;
  logic [kDefNoOfBanks*kAngleLength-1:0] req_angle;
  logic [kDefNoOfBanks-1:0]              ack;
  logic                                  err;
  logic                                  busy;
  logic                                  sg_rd_en;
  logic [kSinogramAddressLength-1:0]     sg_addr;
  logic [kDefDataLength-1:0]             sg_data;
  logic [kDefNoOfBanks-1:0]              fr_wr_en;
  logic [kSLength-1:0]                   fr_wr_addr;
  logic [kDefDataLength-1:0]             fr_wr_data;

  // Scheduler side
  modport master (
    input  req, req_angle, sg_data,
    output ack, err, busy, sg_rd_en, sg_addr, fr_wr_en, fr_wr_addr, fr_wr_data
  );

  // Requester / RAM side
  modport slave (
    output req, req_angle, sg_data,
    input  ack, err, busy, sg_rd_en, sg_addr, fr_wr_en, fr_wr_addr, fr_wr_data
  );

endinterface

// File: rtl/sinogram_fill_scheduler_rr_arbiter.sv
// rtl/sinogram_fill_scheduler_rr_arbiter.sv - rotating-priority one-hot grant
module rr_arbiter
  import sinogram_fill_scheduler_pkg::*;
#(
  parameter int kNoOfBanks = kDefNoOfBanks
) (
  input  logic [kNoOfBanks-1:0]     req,
  input  logic [kBankIdxLength-1:0] rr_ptr,
  output logic [kNoOfBanks-1:0]     grant
);

  logic                      found;
  logic [kBankIdxLength-1:0] idx;

  // Scan banks starting at rr_ptr; the first requester found wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < kNoOfBanks; k++) begin
      idx = kBankIdxLength'((int'(rr_ptr) + k) % kNoOfBanks);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sinogram_fill_scheduler.sv
// rtl/sinogram_fill_scheduler.sv - copies one sinogram line per request into a filtered-RAM bank
module sinogram_fill_scheduler
  import sinogram_fill_scheduler_pkg::*;
#(
  parameter int kNoOfBanks  = kDefNoOfBanks,
  parameter int kLineSize   = kDefLineSize,
  parameter int kNoOfAngles = kDefNoOfAngles,
  parameter int kDataLength = kDefDataLength
) (
  input  logic                    clk,
  input  logic                    reset,
  sinogram_fill_scheduler_if.master bus
);

  state_t                            state;
  logic [kBankIdxLength-1:0]         rr_ptr;
  logic [kBankIdxLength-1:0]         winner;
  logic [kBankIdxLength-1:0]         grant_idx;
  logic [kNoOfBanks-1:0]             grant;
  logic [kNoOfBanks-1:0]             winner_oh;
  logic [kSLength-1:0]               s;
  logic [kSinogramAddressLength-1:0] base;
  logic [kSinogramAddressLength-1:0] line_base;
  logic [kAngleLength-1:0]           angle;
  logic [kDataLength-1:0]            wr_data;

  rr_arbiter #(.kNoOfBanks(kNoOfBanks)) u_arb (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .grant  (grant)
  );

  // Encode the grant and select the current winner's angle field
  always_comb begin
    grant_idx = '0;
    angle     = '0;
    for (int k = 0; k < kNoOfBanks; k++) begin
      if (grant[k]) grant_idx = kBankIdxLength'(k);
      if (winner == kBankIdxLength'(k)) angle = bus.req_angle[k*kAngleLength +: kAngleLength];
    end
  end

  assign winner_oh = kNoOfBanks'(1) << winner;
  assign line_base = kSinogramAddressLength'(angle) << kSLength;

  // RAM data arrives the cycle after the read, which is exactly the write cycle
  assign wr_data        = bus.sg_data;
  assign bus.fr_wr_data = (|bus.fr_wr_en) ? wr_data : '0;

  // Fill sequencer with registered strobes; writes trail reads by one cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      rr_ptr         <= '0;
      winner         <= '0;
      s              <= '0;
      base           <= '0;
      bus.ack        <= '0;
      bus.err        <= 1'b0;
      bus.busy       <= 1'b0;
      bus.sg_rd_en   <= 1'b0;
      bus.sg_addr    <= '0;
      bus.fr_wr_en   <= '0;
      bus.fr_wr_addr <= '0;
    end else begin
      bus.ack <= '0;
      bus.err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|bus.req) begin
            winner   <= grant_idx;
            bus.busy <= 1'b1;
            state    <= S_LATCH;
          end
        end
        S_LATCH: begin
          s <= '0;
          if (int'(angle) >= kNoOfAngles) begin
            bus.ack <= winner_oh;
            bus.err <= 1'b1;
            state   <= S_DONE;
          end else begin
            base         <= line_base;
            bus.sg_rd_en <= 1'b1;
            bus.sg_addr  <= line_base;
            state        <= S_STREAM;
          end
        end
        S_STREAM: begin
          bus.fr_wr_en   <= winner_oh;
          bus.fr_wr_addr <= s;
          if (s == kSLength'(kLineSize - 1)) begin
            bus.sg_rd_en <= 1'b0;
            bus.sg_addr  <= '0;
            state        <= S_DRAIN;
          end else begin
            s           <= s + kSLength'(1);
            bus.sg_addr <= base + kSinogramAddressLength'(s) + kSinogramAddressLength'(1);
          end
        end
        S_DRAIN: begin
          bus.fr_wr_en   <= '0;
          bus.fr_wr_addr <= '0;
          bus.ack        <= winner_oh;
          s              <= '0;
          state          <= S_DONE;
        end
        S_DONE: begin
          bus.busy <= 1'b0;
          rr_ptr   <= (winner == kBankIdxLength'(kNoOfBanks - 1)) ? '0 : winner + kBankIdxLength'(1);
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sinogram_fill_scheduler.sv
// tb/tb_sinogram_fill_scheduler.sv - scoreboard bench for sinogram_fill_scheduler
module tb_sinogram_fill_scheduler;
  import sinogram_fill_scheduler_pkg::*;

  typedef struct {
    logic [3:0]  en;
    logic [7:0]  wa;
    logic [15:0] d;
  } wr_t;

  typedef struct {
    logic [3:0] ack;
    logic       err;
    int         cyc;
  } ack_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_checks;
  int   n_fail;
  int   model_ptr;
  logic chk_zero;

  logic [15:0] rd_q[$];
  wr_t         wr_q[$];
  ack_t        ack_q[$];

  sinogram_fill_scheduler_if bus();

  sinogram_fill_scheduler dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Sinogram RAM: each sample holds its own address; junk when not read
  always @(posedge clk) bus.sg_data <= bus.sg_rd_en ? bus.sg_addr : 16'hdead;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Expected traffic of one fill, plus the model's round-robin pointer
  task automatic push_fill(input int bank, input int angle, input int ack_cyc);
    ack_t a;
    wr_t  w;
    if (angle < 180) begin
      for (int s = 0; s < 256; s++) begin
        rd_q.push_back(16'(angle * 256 + s));
        w.en = 4'(1 << bank);
        w.wa = 8'(s);
        w.d  = 16'(angle * 256 + s);
        wr_q.push_back(w);
      end
    end
    a.ack = 4'(1 << bank);
    a.err = (angle >= 180);
    a.cyc = ack_cyc;
    ack_q.push_back(a);
    model_ptr = (bank + 1) % 4;
  endtask

  task automatic monitor();
    logic [15:0] ea;
    wr_t         w;
    ack_t        a;
    if (chk_zero) begin
      check_eq("rst_ack", 32'(bus.ack), 0);
      check_eq("rst_err", 32'(bus.err), 0);
      check_eq("rst_busy", 32'(bus.busy), 0);
      check_eq("rst_sg_rd_en", 32'(bus.sg_rd_en), 0);
      check_eq("rst_sg_addr", 32'(bus.sg_addr), 0);
      check_eq("rst_fr_wr_en", 32'(bus.fr_wr_en), 0);
      check_eq("rst_fr_wr_addr", 32'(bus.fr_wr_addr), 0);
      check_eq("rst_fr_wr_data", 32'(bus.fr_wr_data), 0);
    end
    if (bus.sg_rd_en) begin
      if (rd_q.size() == 0) check_eq("rd_unexpected", 32'(bus.sg_addr), 32'hffff_ffff);
      else begin
        ea = rd_q.pop_front();
        check_eq("sg_addr", 32'(bus.sg_addr), 32'(ea));
      end
    end
    if (|bus.fr_wr_en) begin
      if (wr_q.size() == 0) check_eq("wr_unexpected", 32'(bus.fr_wr_en), 0);
      else begin
        w = wr_q.pop_front();
        check_eq("fr_wr_en", 32'(bus.fr_wr_en), 32'(w.en));
        check_eq("fr_wr_addr", 32'(bus.fr_wr_addr), 32'(w.wa));
        check_eq("fr_wr_data", 32'(bus.fr_wr_data), 32'(w.d));
      end
    end
    if (|bus.ack) begin
      if (ack_q.size() == 0) check_eq("ack_unexpected", 32'(bus.ack), 0);
      else begin
        a = ack_q.pop_front();
        check_eq("ack", 32'(bus.ack), 32'(a.ack));
        check_eq("err", 32'(bus.err), 32'(a.err));
        check_eq("ack_cycle", 32'(cyc), 32'(a.cyc));
        check_eq("busy_at_ack", 32'(bus.busy), 1);
      end
      bus.req = bus.req & ~bus.ack;
    end else if (bus.err) begin
      check_eq("err_without_ack", 32'(bus.err), 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (ack_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (ack_q.size() != 0) check_eq("drain_timeout", 32'(ack_q.size()), 0);
    ack_q.delete();
    repeat (3) tick();
  endtask

  task automatic request(input int bank, input int angle);
    bus.req_angle[bank*8 +: 8] = 8'(angle);
    bus.req[bank] = 1'b1;
  endtask

  initial begin
    int c0;
    int b;
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    model_ptr = 0;
    chk_zero = 1'b0;
    reset = 1'b1;
    bus.req = '0;
    bus.req_angle = '0;
    repeat (3) tick();
    chk_zero = 1'b1;
    tick();
    chk_zero = 1'b0;
    reset = 1'b0;
    tick();

    // All four banks at once: served in rotating order from pointer 0
    c0 = cyc;
    for (int i = 0; i < 4; i++) request(i, 10 + i);
    b = model_ptr;
    for (int k = 0; k < 4; k++) begin
      push_fill(b, 10 + b, c0 + 259 + 260 * k);
      b = model_ptr;
    end
    drain(1200);

    // Single bank 0, angle 3
    c0 = cyc;
    request(0, 3);
    push_fill(0, 3, c0 + 259);
    drain(400);
    check_eq("busy_idle", 32'(bus.busy), 0);

    // Out-of-range angle is rejected without touching either RAM
    c0 = cyc;
    request(2, 180);
    push_fill(2, 180, c0 + 2);
    drain(20);

    // Last valid angle reaches the top of the address space without wrapping
    c0 = cyc;
    request(3, 179);
    push_fill(3, 179, c0 + 259);
    drain(400);

    // Reset 100 cycles into a fill aborts it silently
    c0 = cyc;
    request(0, 5);
    push_fill(0, 5, c0 + 259);
    while (cyc < c0 + 100) tick();
    reset = 1'b1;
    bus.req = '0;
    tick();
    rd_q.delete();
    wr_q.delete();
    ack_q.delete();
    model_ptr = 0;
    chk_zero = 1'b1;
    tick();
    chk_zero = 1'b0;
    reset = 1'b0;
    repeat (5) tick();

    // A fresh request after the aborted fill completes normally
    c0 = cyc;
    request(1, 7);
    push_fill(1, 7, c0 + 259);
    drain(400);

    check_eq("rd_q_left", 32'(rd_q.size()), 0);
    check_eq("wr_q_left", 32'(wr_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
